spi_event_tx: RTL and testbench

Event-report transmitter for the host SPI link: the fabric pushes 32-bit event words into a small FIFO, and the host drains them with a read command over the same `spi_dev_core` user interface that carries host-to-FPGA messages. The block drives the core's `usr_miso_data` and consumes `usr_miso_ack`, `usr_mosi_stb`/`usr_mosi_data` and the chip-select edge strobes. It sits beside the host-message receiver, which keeps the MOSI side. The block also raises a level `pending` flag so the host can poll or take an interrupt.

---
 rtl/spi_event_tx.sv | 139 +++++++++++++
 tb/tb_spi_event_tx.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_event_tx.sv
// Event-report transmitter: queues 32-bit event words and streams them
// to the host over the SPI core user interface after a read command.
module spi_event_tx #(
    parameter int         DEPTH = 8,
    parameter logic [7:0] CMD   = 8'hF5
) (
    input  logic        clk,
    input  logic        resetq,
    input  logic [31:0] evt_data,
    input  logic        evt_valid,
    input  logic [7:0]  usr_mosi_data,
    input  logic        usr_mosi_stb,
    input  logic        usr_miso_ack,
    input  logic        csn_fall,
    input  logic        csn_rise,
    output logic [7:0]  usr_miso_data,
    output logic        pending,
    output logic        overflow,
    output logic [4:0]  level
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_HDR, S_DATA, S_PAD
    } state_t;

    state_t state, state_nxt;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] wptr, rptr, rd_nxt;
    logic [4:0]    n, n_nxt, cnt, cnt_nxt;
    logic [1:0]    idx, idx_nxt;
    logic          pop, push, drop, hdr_ack, ovf_nxt, upd;
    logic [7:0]    miso_nxt;
    logic [31:0]   head;

    // A pop frees a slot, so a push into a full FIFO survives it.
    assign pop     = (state == S_DATA) && usr_miso_ack && (idx == 2'd3);
    assign push    = evt_valid && ((level < 5'(DEPTH)) || pop);
    assign drop    = evt_valid && !push;
    assign hdr_ack = (state == S_HDR) && usr_miso_ack;
    assign ovf_nxt = drop | (overflow & ~hdr_ack);
    assign rd_nxt  = pop ? rptr + AW'(1) : rptr;
    assign head    = mem[rd_nxt];
    assign pending = |level;

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= evt_data;
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)      level <= level + 5'd1;
            else if (pop && !push) level <= level - 5'd1;
            overflow <= ovf_nxt;
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state         <= S_IDLE;
            n             <= '0;
            cnt           <= '0;
            idx           <= '0;
            usr_miso_data <= 8'h00;
        end else begin
            state <= state_nxt;
            n     <= n_nxt;
            cnt   <= cnt_nxt;
            idx   <= idx_nxt;
            if (upd) usr_miso_data <= miso_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        cnt_nxt   = cnt;
        idx_nxt   = idx;
        if (csn_rise) begin
            state_nxt = S_IDLE;
        end else if (csn_fall) begin
            state_nxt = S_CMD;
        end else begin
            unique case (state)
                S_CMD: if (usr_mosi_stb) begin
                    if (usr_mosi_data == CMD) begin
                        state_nxt = S_HDR;
                        n_nxt     = level;
                    end else begin
                        state_nxt = S_PAD;
                    end
                end
                S_HDR: if (usr_miso_ack) begin
                    idx_nxt   = 2'd0;
                    cnt_nxt   = n;
                    state_nxt = (n == 5'd0) ? S_PAD : S_DATA;
                end
                S_DATA: if (usr_miso_ack) begin
                    idx_nxt = idx + 2'd1;
                    if (idx == 2'd3) begin
                        cnt_nxt = cnt - 5'd1;
                        if (cnt == 5'd1) state_nxt = S_PAD;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output only moves on a trigger so the byte holds between acks.
    always_comb begin
        upd = csn_rise | csn_fall
            | ((state == S_CMD) && usr_mosi_stb)
            | (((state == S_HDR) || (state == S_DATA)) && usr_miso_ack);
        miso_nxt = 8'h00;
        unique case (state_nxt)
            S_HDR:  miso_nxt = {ovf_nxt, 2'b00, n_nxt};
            S_DATA: begin
                unique case (idx_nxt)
                    2'd0: miso_nxt = head[31:24];
                    2'd1: miso_nxt = head[23:16];
                    2'd2: miso_nxt = head[15:8];
                    default: miso_nxt = head[7:0];
                endcase
            end
            default: miso_nxt = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_spi_event_tx.sv
// Bench for spi_event_tx: a queue/byte-stream model checked every cycle
// plus literal expectations from hand-worked transactions.
module tb_spi_event_tx;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        resetq = 1'b0;
    logic [31:0] evt_data = '0;
    logic        evt_valid = 1'b0;
    logic [7:0]  usr_mosi_data = '0;
    logic        usr_mosi_stb = 1'b0;
    logic        usr_miso_ack = 1'b0;
    logic        csn_fall = 1'b0;
    logic        csn_rise = 1'b0;
    logic [7:0]  usr_miso_data;
    logic        pending;
    logic        overflow;
    logic [4:0]  level;

    always #5 clk = ~clk;

    spi_event_tx #(.DEPTH(DEPTH), .CMD(8'hF5)) dut (
        .clk(clk), .resetq(resetq),
        .evt_data(evt_data), .evt_valid(evt_valid),
        .usr_mosi_data(usr_mosi_data), .usr_mosi_stb(usr_mosi_stb),
        .usr_miso_ack(usr_miso_ack),
        .csn_fall(csn_fall), .csn_rise(csn_rise),
        .usr_miso_data(usr_miso_data), .pending(pending),
        .overflow(overflow), .level(level)
    );

    int errors = 0;
    int checks = 0;

    // Model: queued words, sticky drop flag, and the byte stream the
    // current read must produce (header then snapshotted words).
    logic [31:0] q[$];
    logic [7:0]  strm[$];
    bit          m_ovf = 1'b0;
    bit          listening = 1'b0;
    bit          active = 1'b0;
    int          pos = 0;
    logic [7:0]  exp_miso = 8'h00;
    bit          chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("miso", 32'(usr_miso_data), 32'(exp_miso));
            chk("level", 32'(level), 32'(q.size()));
            chk("pending", 32'(pending), 32'(q.size() != 0));
            chk("overflow", 32'(overflow), 32'(m_ovf));
        end
    end

    task automatic model_edge(input bit fall, input bit rise, input bit stb,
                              input logic [7:0] d, input bit ack,
                              input bit pv, input logic [31:0] w);
        int pre;
        bit pop, hdr, drop;
        logic [31:0] wd;
        pre  = q.size();
        pop  = active && ack && pos >= 1 && pos < strm.size()
               && ((pos - 1) % 4 == 3);
        hdr  = active && ack && pos == 0;
        drop = 1'b0;
        if (pop) void'(q.pop_front());
        if (pv) begin
            if (pre < DEPTH || pop) q.push_back(w);
            else drop = 1'b1;
        end
        if (drop) m_ovf = 1'b1;
        else if (hdr) m_ovf = 1'b0;
        if (rise) begin
            listening = 0; active = 0; exp_miso = 8'h00;
        end else if (fall) begin
            listening = 1; active = 0; exp_miso = 8'h00;
        end else if (listening && stb) begin
            listening = 0;
            if (d == 8'hF5) begin
                active = 1;
                pos = 0;
                strm.delete();
                strm.push_back({m_ovf, 2'b00, 5'(pre)});
                for (int k = 0; k < pre; k++) begin
                    wd = q[k];
                    for (int b = 0; b < 4; b++)
                        strm.push_back(wd[31 - 8 * b -: 8]);
                end
                exp_miso = strm[0];
            end else begin
                exp_miso = 8'h00;
            end
        end else if (active && ack && pos < strm.size()) begin
            pos++;
            exp_miso = (pos < strm.size()) ? strm[pos] : 8'h00;
        end
    endtask

    task automatic step(input bit fall, input bit rise, input bit stb,
                        input logic [7:0] d, input bit ack,
                        input bit pv, input logic [31:0] w);
        @(negedge clk);
        csn_fall = fall; csn_rise = rise;
        usr_mosi_stb = stb; usr_mosi_data = d;
        usr_miso_ack = ack; evt_valid = pv; evt_data = w;
        @(posedge clk);
        model_edge(fall, rise, stb, d, ack, pv, w);
        #1;
        csn_fall = 0; csn_rise = 0; usr_mosi_stb = 0;
        usr_miso_ack = 0; evt_valid = 0;
    endtask

    task automatic idle();            step(0, 0, 0, 8'h00, 0, 0, 0); endtask
    task automatic push(input logic [31:0] w); step(0, 0, 0, 8'h00, 0, 1, w); endtask
    task automatic fall();            step(1, 0, 0, 8'h00, 0, 0, 0); endtask
    task automatic rise();            step(0, 1, 0, 8'h00, 0, 0, 0); endtask
    task automatic cmd(input logic [7:0] c); step(0, 0, 1, c, 0, 0, 0); endtask
    task automatic ack();             step(0, 0, 0, 8'h00, 1, 0, 0); endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        resetq = 1'b0;
        q.delete(); strm.delete();
        m_ovf = 0; listening = 0; active = 0; pos = 0; exp_miso = 8'h00;
        repeat (2) @(negedge clk);
        #1 resetq = 1'b1;
    endtask

    task automatic drain();
        int nb;
        nb = q.size() * 4 + 1;
        fall();
        cmd(8'hF5);
        repeat (nb) ack();
        rise();
    endtask

    initial begin
        logic [7:0]  e1[6];
        logic [7:0]  e2[4];
        logic [31:0] wv;
        e1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
        e2 = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

        repeat (3) @(negedge clk);
        #1 resetq = 1'b1;
        chk_en = 1'b1;
        chk("rst_miso", 32'(usr_miso_data), 32'h00);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Basic two-word read
        push(32'h11223344);
        push(32'hAABBCCDD);
        fall();
        cmd(8'hF5);
        chk("t1_hdr", 32'(usr_miso_data), 32'h02);
        for (int i = 0; i < 6; i++) begin
            ack();
            chk("t1_byte", 32'(usr_miso_data), 32'(e1[i]));
        end
        chk("t1_level", 32'(level), 32'd1);
        chk("t1_pending", 32'(pending), 32'd1);
        rise();
        drain();

        // Empty read
        fall();
        cmd(8'hF5);
        chk("t2_hdr", 32'(usr_miso_data), 32'h00);
        repeat (3) begin
            ack();
            chk("t2_byte", 32'(usr_miso_data), 32'h00);
        end
        chk("t2_level", 32'(level), 32'd0);
        chk("t2_pending", 32'(pending), 32'd0);
        rise();

        // Overflow: nine pushes into eight slots
        for (int i = 0; i < 9; i++) push(32'hC0DE0000 + 32'(i));
        chk("t3_level", 32'(level), 32'd8);
        chk("t3_ovf", 32'(overflow), 32'd1);
        fall();
        cmd(8'hF5);
        chk("t3_hdr", 32'(usr_miso_data), 32'h88);
        ack();
        chk("t3_ovf_clr", 32'(overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            for (int b = 0; b < 4; b++) begin
                wv = (32'hC0DE0000 + 32'(i)) >> (24 - 8 * b);
                chk("t3_byte", 32'(usr_miso_data), 32'(wv[7:0]));
                ack();
            end
        end
        chk("t3_pad", 32'(usr_miso_data), 32'h00);
        chk("t3_empty", 32'(level), 32'd0);
        rise();

        // Abort mid-word, then resend in full
        push(32'hDEADBEEF);
        fall();
        cmd(8'hF5);
        repeat (3) ack();
        rise();
        chk("t4_level", 32'(level), 32'd1);
        fall();
        cmd(8'hF5);
        chk("t4_hdr", 32'(usr_miso_data), 32'h01);
        for (int i = 0; i < 4; i++) begin
            ack();
            chk("t4_byte", 32'(usr_miso_data), 32'(e2[i]));
        end
        ack();
        chk("t4_level0", 32'(level), 32'd0);
        rise();

        // Wrong command
        push(32'h01234567);
        fall();
        cmd(8'hF4);
        chk("t5_miso", 32'(usr_miso_data), 32'h00);
        repeat (3) begin
            ack();
            chk("t5_byte", 32'(usr_miso_data), 32'h00);
        end
        chk("t5_level", 32'(level), 32'd1);
        rise();

        // Push during a read is not part of the snapshot
        fall();
        cmd(8'hF5);
        chk("t6_hdr", 32'(usr_miso_data), 32'h01);
        push(32'h89ABCDEF);
        repeat (5) ack();
        chk("t6_pad", 32'(usr_miso_data), 32'h00);
        ack();
        rise();
        chk("t6_level", 32'(level), 32'd1);
        drain();

        // Push while full on the same cycle as a pop
        for (int i = 0; i < 8; i++) push(32'h5A000000 + 32'(i));
        fall();
        cmd(8'hF5);
        chk("t7_hdr", 32'(usr_miso_data), 32'h08);
        repeat (4) ack();
        step(0, 0, 0, 8'h00, 1, 1, 32'hFEEDF00D);
        chk("t7_level", 32'(level), 32'd8);
        chk("t7_ovf", 32'(overflow), 32'd0);
        chk("t7_next", 32'(usr_miso_data), 32'h5A);
        rise();
        drain();

        // csn_rise together with the final-byte ack still pops
        push(32'hCAFEBABE);
        fall();
        cmd(8'hF5);
        repeat (4) ack();
        step(0, 1, 0, 8'h00, 1, 0, 0);
        chk("t8_level", 32'(level), 32'd0);
        chk("t8_miso", 32'(usr_miso_data), 32'h00);

        // Second csn_fall restarts the command phase
        push(32'h0BADC0DE);
        fall();
        cmd(8'hF5);
        ack();
        fall();
        chk("t9_restart", 32'(usr_miso_data), 32'h00);
        cmd(8'hF5);
        chk("t9_hdr", 32'(usr_miso_data), 32'h01);
        ack();
        chk("t9_b0", 32'(usr_miso_data), 32'h0B);
        rise();

        // Reset mid-transfer loses queued words
        push(32'h12345678);
        fall();
        cmd(8'hF5);
        ack();
        do_reset();
        chk("t10_level", 32'(level), 32'd0);
        chk("t10_miso", 32'(usr_miso_data), 32'h00);
        chk("t10_pending", 32'(pending), 32'd0);
        idle();
        idle();

        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
